// File: rtl/hack_alu_mul_seq.sv
// hack_alu_mul_seq: 16-bit shift-and-add multiplier sequencer.
// The product (a*b) mod 2^16 is built by repeated use of a single Hack ALU.
// The ALU does every accumulate and every doubling of the multiplicand. Only
// the one-bit right shift of the multiplier is done outside the ALU.
// The low 16 bits of a two's-complement product match the unsigned product,
// so one result serves both signed and unsigned callers.

// Classic Hack ALU, combinational. The control word is {zx,nx,zy,ny,f,no}.
// The sequencer does not use the zr/ng flags, so this ALU does not produce them.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] x_z, x_n, y_z, y_n, f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    // The adder carry out is dropped, so every sum wraps mod 2^16.
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
endmodule

module hack_alu_mul_seq #(
    // 1: stop as soon as the remaining multiplier bits are all zero.
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // x+y, and "pass x" (zy=ny=1 turns y into all-ones, and f=0 gives x & 16'hFFFF).
    localparam logic [5:0] CTRL_ADD    = 6'b000010;
    localparam logic [5:0] CTRL_PASS_X = 6'b001100;

    state_t      state_q;
    logic [15:0] acc_q;
    logic [15:0] mcand_q;
    logic [15:0] mplier_q;
    logic [3:0]  cnt_q;
    logic [15:0] product_q;
    logic        done_q;
    logic        busy_q;
    logic        ready_q;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_out;

    // Route operands and the control word into the shared ALU according to the current step.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave a value
        // unassigned and infer a latch.
        alu_x    = acc_q;
        alu_y    = mcand_q;
        alu_ctrl = CTRL_PASS_X;
        case (state_q)
            ADD: begin
                alu_x    = acc_q;
                alu_y    = mcand_q;
                alu_ctrl = mplier_q[0] ? CTRL_ADD : CTRL_PASS_X;
            end
            DBL: begin
                alu_x    = mcand_q;
                alu_y    = mcand_q;
                alu_ctrl = CTRL_ADD;
            end
            default: ;
        endcase
    end

    hack_alu u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .zx  (alu_ctrl[5]),
        .nx  (alu_ctrl[4]),
        .zy  (alu_ctrl[3]),
        .ny  (alu_ctrl[2]),
        .f   (alu_ctrl[1]),
        .no  (alu_ctrl[0]),
        .out (alu_out)
    );

    // Sequencer FSM: datapath registers and registered status outputs advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            // NOTE: state uses non-blocking assignments, so every register here
            // reads the pre-edge value of every other one.
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        cnt_q    <= '0;
                        state_q  <= ADD;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                ADD: begin
                    if (EARLY_EXIT && (mplier_q == 16'h0000)) begin
                        // No set bits remain, so acc already holds the product.
                        product_q <= acc_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        acc_q    <= alu_out;
                        mplier_q <= {1'b0, mplier_q[15:1]};
                        state_q  <= DBL;
                    end
                end
                DBL: begin
                    mcand_q <= alu_out;
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        product_q <= acc_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q <= ADD;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign zr      = (product_q == 16'h0000);
    assign ng      = product_q[15];
endmodule

// File: tb/tb_hack_alu_mul_seq.sv
// Testbench for hack_alu_mul_seq. It runs one fixed-latency instance and one
// early-exit instance on the same stimulus. A per-instance behavioural model
// (operation start, latency, expected product) is checked against both
// instances on every cycle. Hand-computed literal results pin the model.
module tb_hack_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;

    logic [1:0]  ready, busy, done, zr, ng;
    logic [15:0] product [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    hack_alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]),
        .product(product[0]), .zr(zr[0]), .ng(ng[0])
    );

    hack_alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]),
        .product(product[1]), .zr(zr[1]), .ng(ng[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected number of clock edges from acceptance to the cycle in which done is high.
    function automatic int exp_lat(input bit ee, input logic [15:0] bv);
        int k = 0;
        if (!ee) return 32;
        for (int i = 0; i < 16; i++) if (bv[i]) k = i + 1;
        return (2 * k + 1 < 32) ? 2 * k + 1 : 32;
    endfunction

    // Behavioural model: one operation at a time, a latency count and the expected product.
    logic        m_active [2];
    int          m_n      [2];
    int          m_lat    [2];
    logic [15:0] m_res    [2];
    logic [15:0] m_prod   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] <= 1'b0;
                m_n[i]      <= 0;
                m_lat[i]    <= 0;
                m_res[i]    <= '0;
                m_prod[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    if (start) begin
                        m_active[i] <= 1'b1;
                        m_n[i]      <= 0;
                        m_lat[i]    <= exp_lat(i == 1, b);
                        m_res[i]    <= a * b;
                    end
                end else begin
                    m_n[i] <= m_n[i] + 1;
                    if (m_n[i] + 1 == m_lat[i]) m_prod[i] <= m_res[i];
                    if (m_n[i] == m_lat[i]) m_active[i] <= 1'b0;
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(!m_active[i]));
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_active[i]));
                check($sformatf("done[%0d]", i), 32'(done[i]),
                      32'(m_active[i] && (m_n[i] == m_lat[i])));
                check($sformatf("product[%0d]", i), 32'(product[i]), 32'(m_prod[i]));
                check($sformatf("zr[%0d]", i), 32'(zr[i]), 32'(m_prod[i] == 16'h0000));
                check($sformatf("ng[%0d]", i), 32'(ng[i]), 32'(m_prod[i][15]));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (ready !== 2'b11 && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (ready !== 2'b11) check("wait_idle_timeout", 32'(ready), 32'h3);
    endtask

    // Pulse start for one edge, then watch 40 edges. Record when each instance
    // raises done and what product it shows then.
    task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_p, input int lat0, input int lat1);
        int          got_lat [2];
        logic [15:0] got_p   [2];
        got_lat[0] = -1;
        got_lat[1] = -1;
        got_p[0]   = 'x;
        got_p[1]   = 'x;
        wait_idle();
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #2;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (done[i] && got_lat[i] < 0) begin
                    got_lat[i] = n;
                    got_p[i]   = product[i];
                    check({name, "_busy_at_done"}, 32'(busy[i]), 32'h1);
                end
            end
        end
        check({name, "_lat0"}, got_lat[0], lat0);
        check({name, "_lat1"}, got_lat[1], lat1);
        check({name, "_prod0"}, 32'(got_p[0]), 32'(exp_p));
        check({name, "_prod1"}, 32'(got_p[1]), 32'(exp_p));
    endtask

    initial begin
        int          first_done;
        int          second_done;
        int          done_seen;
        logic [15:0] first_p;
        logic [15:0] second_p;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] full;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        // Literal reset values.
        check("rst_ready", 32'(ready), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_product", 32'(product[0]), 32'h0);
        check("rst_zr", 32'(zr), 32'h3);
        check("rst_ng", 32'(ng), 32'h0);

        // Literal products and latencies.
        run_op("mul_3x5", 16'h0003, 16'h0005, 16'h000F, 32, 7);
        check("ng_3x5", 32'(ng[0]), 32'h0);
        check("zr_3x5", 32'(zr[0]), 32'h0);
        run_op("mul_m1x7", 16'hFFFF, 16'h0007, 16'hFFF9, 32, 7);
        check("ng_m1x7", 32'(ng[0]), 32'h1);
        run_op("mul_wrap", 16'h1234, 16'h0010, 16'h2340, 32, 11);
        run_op("mul_b0", 16'h0009, 16'h0000, 16'h0000, 32, 1);
        check("zr_b0", 32'(zr[1]), 32'h1);
        run_op("mul_9x2", 16'h0009, 16'h0002, 16'h0012, 32, 5);
        run_op("mul_bfull", 16'h0003, 16'hFFFF, 16'hFFFD, 32, 32);

        // Hold start high and change the operands mid-operation.
        wait_idle();
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = 16'h0003;
        b     = 16'h0005;
        first_done  = -1;
        second_done = -1;
        first_p     = 'x;
        second_p    = 'x;
        @(posedge clk);
        #2;
        a = 16'h0007;
        b = 16'h0006;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                a = 16'h0007;
                b = 16'h0006;
            end
            if (done[0]) begin
                if (first_done < 0) begin
                    first_done = n;
                    first_p    = product[0];
                end else if (second_done < 0) begin
                    second_done = n;
                    second_p    = product[0];
                end
            end
        end
        start = 1'b0;
        check("held_first_lat", first_done, 32);
        check("held_first_prod", 32'(first_p), 32'h000F);
        check("held_second_lat", second_done, 66);
        check("held_second_prod", 32'(second_p), 32'h002A);

        // Reset in the middle of an operation.
        wait_idle();
        @(posedge clk);
        #2;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h5678;
        @(posedge clk);
        #2;
        start = 1'b0;
        done_seen = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (done[0]) done_seen++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_product", 32'(product[0]), 32'h0);
        check("midrst_busy", 32'(busy[0]), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (done[0]) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op("after_rst", 16'h00FF, 16'h0101, 16'hFFFF, 32, 19);

        // Random operands, biased so that every multiplier width appears.
        for (int t = 0; t < 200; t++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom >> $urandom_range(16, 32));
            full = 32'(ra) * 32'(rb);
            run_op("rand", ra, rb, full[15:0], 32, exp_lat(1'b1, rb));
        end

        wait_idle();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
